// File: rtl/subs_pkg.sv
// Shared constants and types for the iterative PRESENT substitution layer.
package subs_pkg;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Block must be 64/128 bits; lanes a power of two dividing the nibble count.
  function automatic bit legal_cfg(int unsigned bw, int unsigned lanes);
    if (bw != 64 && bw != 128) return 1'b0;
    if (lanes == 0) return 1'b0;
    if ((lanes & (lanes - 1)) != 0) return 1'b0;
    return ((bw / 4) % lanes) == 0;
  endfunction

endpackage

// File: rtl/subs_layer_iter_if.sv
// Valid/ready input and output channels of the substitution layer.
interface subs_layer_iter_if #(
  parameter int unsigned BLOCK_WIDTH = 64
);
  logic                   in_valid;
  logic                   in_ready;
  logic [BLOCK_WIDTH-1:0] in_data;
  logic                   in_decrypt;
  logic                   out_valid;
  logic                   out_ready;
  logic [BLOCK_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sbox4_dual.sv
// Single 4-bit PRESENT S-box lane, forward or inverse selected by decrypt.
module sbox4_dual
  import subs_pkg::*;
(
  input  logic [3:0] nib_in,
  input  logic       decrypt,
  output logic [3:0] nib_out
);
  assign nib_out = decrypt ? SBOX_INV[nib_in] : SBOX_FWD[nib_in];
endmodule

// File: rtl/subs_layer_iter.sv
// Iterative substitution layer: LANES S-boxes sweep the block in STEPS cycles.
module subs_layer_iter
  import subs_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = 64,
  parameter int unsigned LANES       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  subs_layer_iter_if.slave  bus,
  output logic              busy_o
);
  localparam int unsigned NIB   = BLOCK_WIDTH / 4;
  localparam int unsigned STEPS = NIB / LANES;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned GRP_W = LANES * 4;

  if (!legal_cfg(BLOCK_WIDTH, LANES)) begin : g_cfg_err
    $error("subs_layer_iter: illegal BLOCK_WIDTH/LANES combination");
  end

  state_e                 state_q, state_d;
  logic [BLOCK_WIDTH-1:0] data_q, data_d;
  logic                   mode_q, mode_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, busy_q;
  logic                   ready_int;
  logic [31:0]            grp_off;
  logic [GRP_W-1:0]       grp_in, grp_out;

  assign grp_off = 32'(cnt_q) * GRP_W;
  assign grp_in  = data_q[grp_off +: GRP_W];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox4_dual u_sbox (
      .nib_in  (grp_in[4*l +: 4]),
      .decrypt (mode_q),
      .nib_out (grp_out[4*l +: 4])
    );
  end

  assign ready_int    = (state_q == StIdle) || (state_q == StDone && bus.out_ready);
  // Held low during reset so upstream never sees a phantom acceptance.
  assign bus.in_ready = rst_n && ready_int;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          mode_d  = bus.in_decrypt;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        data_d[grp_off +: GRP_W] = grp_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            data_d  = bus.in_data;
            mode_d  = bus.in_decrypt;
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d == StDone);
      busy_q      <= (state_d == StRun);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_subs_layer_iter.sv
// Checks four configurations of subs_layer_iter against a nibble-wise reference model.
module tb_subs_layer_iter;

  localparam int BW_T [4] = '{64, 128, 128, 64};
  localparam int LN_T [4] = '{4, 1, 32, 16};
  localparam logic [3:0] FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_t  [4];
  logic         in_dec_t    [4];
  logic         out_ready_t [4];
  logic [127:0] in_data_t   [4];
  wire  [3:0]   in_ready_w;
  wire  [3:0]   out_valid_w;
  wire  [3:0]   busy_w;
  wire  [127:0] out_data_w  [4];

  int total = 0;
  int bad   = 0;

  subs_layer_iter_if #(.BLOCK_WIDTH(64))  if0 ();
  subs_layer_iter_if #(.BLOCK_WIDTH(128)) if1 ();
  subs_layer_iter_if #(.BLOCK_WIDTH(128)) if2 ();
  subs_layer_iter_if #(.BLOCK_WIDTH(64))  if3 ();

  assign if0.in_valid = in_valid_t[0];  assign if0.in_decrypt = in_dec_t[0];
  assign if0.out_ready = out_ready_t[0]; assign if0.in_data = in_data_t[0][63:0];
  assign in_ready_w[0] = if0.in_ready;  assign out_valid_w[0] = if0.out_valid;
  assign out_data_w[0] = {64'd0, if0.out_data};
  assign if1.in_valid = in_valid_t[1];  assign if1.in_decrypt = in_dec_t[1];
  assign if1.out_ready = out_ready_t[1]; assign if1.in_data = in_data_t[1];
  assign in_ready_w[1] = if1.in_ready;  assign out_valid_w[1] = if1.out_valid;
  assign out_data_w[1] = if1.out_data;
  assign if2.in_valid = in_valid_t[2];  assign if2.in_decrypt = in_dec_t[2];
  assign if2.out_ready = out_ready_t[2]; assign if2.in_data = in_data_t[2];
  assign in_ready_w[2] = if2.in_ready;  assign out_valid_w[2] = if2.out_valid;
  assign out_data_w[2] = if2.out_data;
  assign if3.in_valid = in_valid_t[3];  assign if3.in_decrypt = in_dec_t[3];
  assign if3.out_ready = out_ready_t[3]; assign if3.in_data = in_data_t[3][63:0];
  assign in_ready_w[3] = if3.in_ready;  assign out_valid_w[3] = if3.out_valid;
  assign out_data_w[3] = {64'd0, if3.out_data};

  subs_layer_iter #(.BLOCK_WIDTH(64), .LANES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .busy_o(busy_w[0]));
  subs_layer_iter #(.BLOCK_WIDTH(128), .LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .busy_o(busy_w[1]));
  subs_layer_iter #(.BLOCK_WIDTH(128), .LANES(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .busy_o(busy_w[2]));
  subs_layer_iter #(.BLOCK_WIDTH(64), .LANES(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3), .busy_o(busy_w[3]));

  typedef struct {
    logic [63:0] d;
    bit          dec;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inverse is found by searching the forward table rather than a second table.
  function automatic logic [127:0] model(input logic [127:0] x, input int bw, input bit dec);
    logic [127:0] r = '0;
    for (int n = 0; n < bw / 4; n++) begin
      if (!dec) begin
        r[4*n +: 4] = FWD[x[4*n +: 4]];
      end else begin
        for (int j = 0; j < 16; j++)
          if (FWD[j] == x[4*n +: 4]) r[4*n +: 4] = 4'(j);
      end
    end
    return r;
  endfunction

  task automatic run_block(input int i, input logic [127:0] d, input bit dec, input bit toggle,
                           output logic [127:0] res, output int lat, output bit ok);
    int g = 0;
    in_data_t[i]  = d;
    in_dec_t[i]   = dec;
    in_valid_t[i] = 1'b1;
    while (!in_ready_w[i] && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 200) chk("accept_timeout", 128'(g), 128'd0);
    @(posedge clk); #1;
    in_valid_t[i] = 1'b0;
    in_data_t[i]  = ~d;
    lat = 0;
    ok  = 1'b1;
    while (!out_valid_w[i] && lat < 200) begin
      if (in_ready_w[i] || !busy_w[i]) ok = 1'b0;
      if (toggle) in_dec_t[i] = ~in_dec_t[i];
      @(posedge clk); #1; lat++;
    end
    res = out_data_w[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [6];
    logic [127:0] res, held, back, x;
    int           lat;
    bit           ok, stable;

    vecs[0] = '{64'h0, 1'b0, 64'hCCCCCCCCCCCCCCCC};
    vecs[1] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
    vecs[2] = '{64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF};
    vecs[3] = '{64'h0, 1'b1, 64'h5555555555555555};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222};
    vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hAAAAAAAAAAAAAAAA};

    for (int i = 0; i < 4; i++) begin
      in_valid_t[i] = 1'b0; in_dec_t[i] = 1'b0; out_ready_t[i] = 1'b1; in_data_t[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready_w[0]), 128'd0);
    chk("rst_out_valid", 128'(out_valid_w[0]), 128'd0);
    chk("rst_busy", 128'(busy_w[0]), 128'd0);
    chk("rst_out_data", out_data_w[0], 128'd0);
    #3 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 128'(in_ready_w), 128'hF);

    // Directed 64/4 vectors
    foreach (vecs[v]) begin
      run_block(0, 128'(vecs[v].d), vecs[v].dec, 1'b0, res, lat, ok);
      chk($sformatf("vec%0d_data", v), res, 128'(vecs[v].exp));
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'd4);
      chk($sformatf("vec%0d_run_flags", v), 128'(ok), 128'd1);
    end

    // Backpressure then simultaneous consume/accept
    @(posedge clk); #1;
    out_ready_t[0] = 1'b0;
    run_block(0, 128'h0123456789ABCDEF, 1'b0, 1'b0, res, lat, ok);
    chk("bp_first_data", res, 128'hC56B90AD3EF84712);
    held = res;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid_w[0] || out_data_w[0] !== held || in_ready_w[0]) stable = 1'b0;
    end
    chk("bp_hold_stable", 128'(stable), 128'd1);
    in_data_t[0] = 128'h0; in_dec_t[0] = 1'b0; in_valid_t[0] = 1'b1; out_ready_t[0] = 1'b1;
    #1 chk("bp_in_ready_done", 128'(in_ready_w[0]), 128'd1);
    @(posedge clk); #1;
    in_valid_t[0] = 1'b0;
    chk("bp_swap_out_valid", 128'(out_valid_w[0]), 128'd0);
    chk("bp_swap_busy", 128'(busy_w[0]), 128'd1);
    lat = 0;
    while (!out_valid_w[0] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_swap_latency", 128'(lat), 128'd4);
    chk("bp_swap_data", out_data_w[0], 128'hCCCCCCCCCCCCCCCC);

    // Mode captured only at acceptance
    run_block(0, 128'h0123456789ABCDEF, 1'b0, 1'b1, res, lat, ok);
    chk("mode_latch_fwd", res, 128'hC56B90AD3EF84712);
    run_block(0, 128'hC56B90AD3EF84712, 1'b1, 1'b1, res, lat, ok);
    chk("mode_latch_inv", res, 128'h0123456789ABCDEF);

    // Reset in the middle of a block
    @(posedge clk); #1;
    in_data_t[0] = 128'h0123456789ABCDEF; in_dec_t[0] = 1'b0; in_valid_t[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_t[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid_w[0]), 128'd0);
    chk("midrst_out_data", out_data_w[0], 128'd0);
    chk("midrst_busy", 128'(busy_w[0]), 128'd0);
    chk("midrst_in_ready", 128'(in_ready_w[0]), 128'd0);
    @(posedge clk); #4;
    rst_n = 1'b1;
    #1 chk("midrst_release_ready", 128'(in_ready_w[0]), 128'd1);
    run_block(0, 128'hFEDCBA9876543210, 1'b0, 1'b0, res, lat, ok);
    chk("midrst_fresh_data", res, model(128'hFEDCBA9876543210, 64, 1'b0));
    chk("midrst_fresh_latency", 128'(lat), 128'd4);

    // Random sweep over all configurations with round-trip check
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) begin
        bit dec;
        x = {$urandom, $urandom, $urandom, $urandom};
        if (BW_T[i] == 64) x[127:64] = '0;
        dec = 1'($urandom);
        run_block(i, x, dec, 1'b0, res, lat, ok);
        chk($sformatf("rnd%0d_%0d_data", i, k), res, model(x, BW_T[i], dec));
        chk($sformatf("rnd%0d_%0d_latency", i, k), 128'(lat), 128'(BW_T[i] / 4 / LN_T[i]));
        chk($sformatf("rnd%0d_%0d_run_flags", i, k), 128'(ok), 128'd1);
        run_block(i, res, ~dec, 1'b0, back, lat, ok);
        chk($sformatf("rnd%0d_%0d_roundtrip", i, k), back, x);
      end
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
